// File: rtl/route_table_server.sv
// route_table_server
//   Builds, holds and serves the destination -> output-port table that a
//   router loads through table_addr/table_data. After reset the table is
//   filled with XY mesh routes for node ID. The router is held in reset until
//   the table is complete, and its load is then supervised by a watchdog.
//   In RUN, per-entry overrides are accepted and a commit forces a reload.
//
// Ports
//   clk         clock
//   reset       asynchronous active-low reset
//   table_addr  entry index driven by the router
//   table_data  table entry at table_addr (combinational, valid in all states)
//   rtr_reset   active-high reset to the router (high in INIT and HOLD)
//   rtr_ready   router load complete
//   cfg_valid   override write request (honoured only in RUN)
//   cfg_addr    override entry index
//   cfg_port    override port value
//   cfg_ready   overrides accepted this cycle (high only in RUN)
//   cfg_commit  single-cycle pulse: reload the router with the current table
//   busy        high in every state except RUN
//   load_err    sticky: a router load exceeded the watchdog limit
//   state_dbg   current FSM state (0 INIT, 1 HOLD, 2 LOAD, 3 RUN)
//
// Handshake: the override interface is valid/ready. A write transfers on any
// rising clk edge where cfg_valid and cfg_ready are both high. cfg_ready
// depends only on the state, never on cfg_valid, so writes in RUN are never
// stalled and the last write to an address wins.
`timescale 1ns/1ps

module route_table_server #(
  parameter int ID        = 0,
  parameter int DEST_BITS = 7,
  parameter int X_BITS    = 3,
  parameter int PORT_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DEST_BITS-1:0] table_addr,
  output logic [PORT_BITS-1:0] table_data,
  output logic                 rtr_reset,
  input  logic                 rtr_ready,
  input  logic                 cfg_valid,
  input  logic [DEST_BITS-1:0] cfg_addr,
  input  logic [PORT_BITS-1:0] cfg_port,
  output logic                 cfg_ready,
  input  logic                 cfg_commit,
  output logic                 busy,
  output logic                 load_err,
  output logic [1:0]           state_dbg
);

  localparam int DESTS     = 2 ** DEST_BITS;
  localparam int Y_BITS    = DEST_BITS - X_BITS;
  localparam int WDOG_MAX  = DESTS + 8;
  localparam int WDOG_BITS = $clog2(WDOG_MAX + 1);

  localparam logic [DEST_BITS-1:0] OWN       = DEST_BITS'(ID);
  localparam logic [X_BITS-1:0]    OWN_X     = OWN[X_BITS-1:0];
  localparam logic [Y_BITS-1:0]    OWN_Y     = OWN[DEST_BITS-1:X_BITS];
  localparam logic [DEST_BITS:0]   IDX_LAST  = (DEST_BITS + 1)'(DESTS - 1);
  localparam logic [WDOG_BITS-1:0] WDOG_LIM  = WDOG_BITS'(WDOG_MAX);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_HOLD = 2'd1,
    S_LOAD = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  state_t                 state, state_n;
  logic [DEST_BITS:0]     idx, idx_n;
  logic                   hold, hold_n;
  logic [WDOG_BITS-1:0]   wdog, wdog_n;
  logic                   err_n;

  logic [PORT_BITS-1:0]   table_q [DESTS];

  // XY dimension-ordered route: resolve x first, then y, else local.
  // Ports: 0 local, 1 north, 2 east, 3 south, 4 west.
  function automatic logic [PORT_BITS-1:0] xy_port(input logic [DEST_BITS-1:0] d);
    logic [X_BITS-1:0] dx;
    logic [Y_BITS-1:0] dy;
    dx = d[X_BITS-1:0];
    dy = d[DEST_BITS-1:X_BITS];
    if (dx > OWN_X)      xy_port = PORT_BITS'(2);
    else if (dx < OWN_X) xy_port = PORT_BITS'(4);
    else if (dy > OWN_Y) xy_port = PORT_BITS'(3);
    else if (dy < OWN_Y) xy_port = PORT_BITS'(1);
    else                 xy_port = PORT_BITS'(0);
  endfunction

  // Table storage has no reset: INIT rewrites every entry before the router
  // is released, so the contents before that are never observed.
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      table_q[idx[DEST_BITS-1:0]] <= xy_port(idx[DEST_BITS-1:0]);
    end else if (state == S_RUN && cfg_valid) begin
      table_q[cfg_addr] <= cfg_port;
    end
  end

  assign table_data = table_q[table_addr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_INIT;
      idx      <= '0;
      hold     <= 1'b0;
      wdog     <= '0;
      load_err <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      hold     <= hold_n;
      wdog     <= wdog_n;
      load_err <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    hold_n  = hold;
    wdog_n  = wdog;
    err_n   = load_err;
    unique case (state)
      S_INIT: begin
        idx_n = idx + 1'b1;
        if (idx == IDX_LAST) begin
          state_n = S_HOLD;
          idx_n   = '0;
          hold_n  = 1'b0;
        end
      end
      // Two cycles of router reset: hold=0 on the first, hold=1 on the second.
      S_HOLD: begin
        if (hold) begin
          state_n = S_LOAD;
          wdog_n  = '0;
        end else begin
          hold_n = 1'b1;
        end
      end
      S_LOAD: begin
        if (rtr_ready) begin
          state_n = S_RUN;
        end else if (wdog == WDOG_LIM) begin
          err_n   = 1'b1;
          state_n = S_HOLD;
          hold_n  = 1'b0;
        end else begin
          wdog_n = wdog + 1'b1;
        end
      end
      S_RUN: begin
        // A same-cycle cfg_valid write lands at this edge via table_q, so
        // the reload that follows sees it.
        if (cfg_commit) begin
          state_n = S_HOLD;
          hold_n  = 1'b0;
        end
      end
      default: state_n = S_INIT;
    endcase
  end

  // Outputs decode the registered state only, so an asynchronous reset
  // forces them to their reset values immediately.
  always_comb begin
    rtr_reset = (state == S_INIT) || (state == S_HOLD);
    cfg_ready = (state == S_RUN);
    busy      = (state != S_RUN);
    state_dbg = state;
  end

endmodule

// File: doc/route_table_server.md
# route_table_server

Per-router routing-table host: it builds, holds and serves the destination-to-output-port table that a `router` loads through its `table_addr`/`table_data` interface. After reset it fills the table with dimension-ordered (XY) mesh routes for its node, holds the router in reset until the table is complete, then releases it and supervises the router's load. At runtime it accepts per-entry overrides and, on commit, forces the router to reload.

## Interface
- `ID`, 0, own node address, `{y, x}` packed as a destination address.
- `DEST_BITS`, 7, destination address width; `DESTS = 2**DEST_BITS` entries.
- `X_BITS`, 3, low bits of an address giving x; the upper `DEST_BITS-X_BITS` bits give y.
- `PORT_BITS`, 8, width of a table entry (output port number).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `table_addr`  in  DEST_BITS  entry index driven by the router.
- `table_data`  out  PORT_BITS  table entry for `table_addr`.
- `rtr_reset`  out  1  active-high reset to the router.
- `rtr_ready`  in  1  router `ready`.
- `cfg_valid`  in  1  override write request.
- `cfg_addr`  in  DEST_BITS  override entry index.
- `cfg_port`  in  PORT_BITS  override port value.
- `cfg_ready`  out  1  overrides accepted this cycle.
- `cfg_commit`  in  1  single-cycle pulse: reload router with current table.
- `busy`  out  1  high in every state except RUN.
- `load_err`  out  1  sticky: router load exceeded timeout.

## Operation
- Port encoding: 0 local, 1 north, 2 east, 3 south, 4 west; zero-extended to PORT_BITS.
- XY rule for entry d (dx, dy vs own ox, oy, unsigned compare):
  - dx>ox → 2; dx<ox → 4;
  - else dy>oy → 3; dy<oy → 1;
  - else 0.
- Storage: DESTS × PORT_BITS register array.
- `table_data = table[table_addr]`, purely combinational, valid in all states.
- States:
  - INIT: `idx` counts 0..DESTS-1, writing the XY entry for `idx` each cycle. After `idx`=DESTS-1 → HOLD.
  - HOLD: two cycles with `rtr_reset`=1 → LOAD.
  - LOAD: `rtr_reset`=0; `wdog` counts up from 0.
    - `rtr_ready`=1 → RUN.
    - `wdog`=DESTS+8 → set `load_err`, → HOLD (retry).
  - RUN: `cfg_ready`=1.
    - `cfg_valid` writes `table[cfg_addr]=cfg_port` at that edge.
    - `cfg_commit` → HOLD.
- `cfg_valid` outside RUN is ignored; no write occurs.
- `cfg_commit` outside RUN is ignored.
- `cfg_valid` with `cfg_commit` in the same cycle: the write lands at that edge, then → HOLD, so the reload sees the new value.
- `cfg_valid` is never stalled in RUN: one write per cycle, and the last write to the same address wins.
- `load_err` is cleared only by `reset`.
- `idx` has DEST_BITS+1 bits, so the terminal compare is clean at DESTS-1.
- `wdog` width is sufficient for DESTS+8 and saturates at that value.

## Timing
- Reset values: state INIT, `idx`=0, `wdog`=0, `rtr_reset`=1, `cfg_ready`=0, `busy`=1, `load_err`=0.
  - Table contents are unspecified until INIT rewrites them; the router is held in reset meanwhile.
- Edge 1 after `reset` rises writes entry 0. Edge DESTS writes entry DESTS-1.
- `rtr_reset` falls after edge DESTS+2. With DEST_BITS=7 that is edge 130.
- The router reads one entry per cycle, with table data sampled at its edge, and raises `ready` after DESTS cycles.
- RUN is entered on the edge after `rtr_ready` is first sampled high; `busy` and `cfg_ready` change on that edge.
- Commit sequence:
  - `cfg_commit` sampled at edge n.
  - `rtr_reset`=1 and `busy`=1 from edge n through edge n+2.
  - LOAD starts at edge n+2, with `rtr_reset` falling at that edge.
- `reset` asserted mid-operation (any state): all outputs immediately take their reset values. INIT restarts from `idx`=0 after release.

## Test plan
- ID={y=2,x=3}, reset release:
  - entries {2,3}→0, {2,5}→2, {2,1}→4, {4,3}→3, {0,3}→1, {7,0}→4;
  - `rtr_reset` falls at edge 130.
- Router model raises `ready` 128 cycles after release → `busy` falls and `cfg_ready` rises one cycle later; `load_err`=0.
- In RUN, write {addr 0x15, port 4}, then `cfg_commit` → `rtr_reset` high for edges n..n+2; the router reload sees `table_data`=4 at address 0x15.
- Same-cycle `cfg_valid`(0x20→1) and `cfg_commit` → write retained and HOLD entered; back-to-back writes to 0x20 (1 then 3) leave 3.
- Router `ready` tied low → after DESTS+8 LOAD cycles `load_err`=1 and HOLD re-entered; `load_err` remains 1 after `ready` is later released and RUN is reached.
- `reset` pulsed low mid-INIT (`idx`=40) and mid-RUN → `rtr_reset`=1, `cfg_ready`=0 asynchronously; full INIT repeats and `cfg_valid` during INIT/LOAD writes nothing.
